uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive FIFO of the 16550 controller: downstream of the RX deserializer. Captures each received
//  character plus its error flags (pe/fe/bi) on push and presents the oldest entry to the RBR/LSR
//  register logic. Provides FIFO status, RX trigger-level match and error-in-FIFO flag (LSR[7]).
// PARAMETERS
//  DEPTH  16  entries in FIFO mode; power of two, >= 4
//  AW     4   pointer width, $clog2(DEPTH)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous active-high reset
//  push        in   1      one-cycle strobe from RX deserializer: write entry
//  din         in   8      received character (unused upper bits are zero for short words)
//  pe_in       in   1      parity error of this character
//  fe_in       in   1      framing error of this character
//  bi_in       in   1      break indication of this character
//  pop         in   1      one-cycle strobe: RBR read, discard head entry
//  fifo_en     in   1      FCR[0]; 0 = 16450 mode (single holding register)
//  clr         in   1      FCR[1] strobe: flush FIFO
//  trig_lvl    in   2      FCR[7:6] RX trigger select
//  dout        out  8      head entry data (first-word fall-through)
//  pe_out      out  1      head entry parity error
//  fe_out      out  1      head entry framing error
//  bi_out      out  1      head entry break
//  empty       out  1      no entries (LSR[0] = ~empty)
//  full        out  1      count == capacity
//  count       out  AW+1   current occupancy
//  overrun     out  1      one-cycle pulse: push rejected (LSR[1] source)
//  trig_hit    out  1      count >= trigger level (RDA interrupt source)
//  err_in_fifo out  1      >= 1 stored entry has pe|fe|bi set (LSR[7])
// BEHAVIOUR
//  - Clock clk; reset synchronous active-high: all pointers, count, error counter cleared;
//    empty=1, full=0, count=0, overrun=0, trig_hit=0, err_in_fifo=0, dout/pe_out/fe_out/bi_out=0.
//  - Capacity = DEPTH when fifo_en=1, 1 when fifo_en=0. Change of fifo_en flushes (as clr).
//  - Entry = {bi,fe,pe,data[7:0]}, 11 bits. Head visible combinationally; pop latency 0, new head
//    visible the cycle after pop. Outputs read 0 when empty.
//  - Push when not full: write at wptr, wptr wraps modulo DEPTH, count+1.
//  - Push when full, no pop: entry dropped, contents unchanged, overrun pulses 1 cycle.
//  - Push and pop same cycle: non-empty -> both happen, count unchanged, no overrun even if full;
//    empty -> push only (pop ignored).
//  - Pop when empty: ignored, no state change, no error.
//  - clr (or rst) has priority over push/pop same cycle: flush, the push is lost, no overrun.
//  - trig_lvl 00/01/10/11 -> 1/4/8/14 entries; trig_hit = fifo_en ? count>=lvl : ~empty (comb).
//  - err_in_fifo: counter of stored error entries; +1 on accepted push with any error flag,
//    -1 on pop of head with any error flag; both same cycle -> net; flush -> 0.
//  - count is AW+1 bits; never exceeds DEPTH; pointers AW bits, wrap silently.
// CONFIGURATION
//  - UART_RX_TIMEOUT_EN defined: extra input char_tick (1 pulse per character time) and output
//    timeout (registered). Idle counter cleared on push, pop, clr, rst; increments on char_tick
//    while non-empty; timeout=1 when counter reaches 4 and FIFO non-empty, until next push/pop/flush.
//  - Not defined: no char_tick/timeout ports, no counter logic.
// STRUCTURE
//  - uart_pkg: rx_entry_t packed struct {bi,fe,pe,data}; trig-level encodings and
//    TRIG_1/4/8/14 constants; character-timeout threshold constant (4).
//  - Sub-module uart_fifo_mem: DEPTH x 11 register array, sync write, async read by address.
//  - Pointer/count/flag control and timeout counter stay in uart_rx_fifo.
// TESTING
//  1. rst, push 0x41,0x42,0x43 -> count=3, dout=0x41; pop x3 -> 0x42,0x43, then empty=1, count=0.
//  2. fifo_en=1, 17 pushes 0x00..0x10 -> full=1 after 16th, overrun pulse on 17th, head 0x00,
//     tail 0x0F; push+pop same cycle while full -> count stays 16, no overrun.
//  3. trig_lvl=10: pushes 1..8 -> trig_hit rises exactly on 8th push, falls after one pop.
//  4. push 0x55 with fe_in=1 among clean chars -> err_in_fifo=1 until that entry popped, then 0.
//  5. fifo_en=0: push 0x11 then 0x22 without pop -> overrun pulse, dout stays 0x11; clr with
//     push same cycle -> empty=1, no overrun.
//  6. UART_RX_TIMEOUT_EN: 1 entry, 4 char_tick pulses -> timeout=1; pop -> timeout=0;
//     empty FIFO with 10 ticks -> timeout stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 16550 receive path.
package uart_pkg;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  localparam logic [1:0] TRIG_SEL_1  = 2'b00;
  localparam logic [1:0] TRIG_SEL_4  = 2'b01;
  localparam logic [1:0] TRIG_SEL_8  = 2'b10;
  localparam logic [1:0] TRIG_SEL_14 = 2'b11;

  localparam int unsigned TRIG_1  = 1;
  localparam int unsigned TRIG_4  = 4;
  localparam int unsigned TRIG_8  = 8;
  localparam int unsigned TRIG_14 = 14;

  // Idle character times with data waiting before the timeout flag asserts.
  localparam logic [2:0] CHAR_TO_THR = 3'd4;

  function automatic int unsigned trig_level(input logic [1:0] sel);
    case (sel)
      TRIG_SEL_1: return TRIG_1;
      TRIG_SEL_4: return TRIG_4;
      TRIG_SEL_8: return TRIG_8;
      default:    return TRIG_14;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Receive FIFO storage: DEPTH x rx_entry_t, synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rx_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output rx_entry_t     rdata
);

  rx_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// 16550 receive FIFO: first-word fall-through, error tracking, trigger level.
// Optional character timeout built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pe_in,
  input  logic          fe_in,
  input  logic          bi_in,
  input  logic          pop,
  input  logic          fifo_en,
  input  logic          clr,
  input  logic [1:0]    trig_lvl,
`ifdef UART_RX_TIMEOUT_EN
  input  logic          char_tick,
  output logic          timeout,
`endif
  output logic [7:0]    dout,
  output logic          pe_out,
  output logic          fe_out,
  output logic          bi_out,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          trig_hit,
  output logic          err_in_fifo
);

  localparam logic [AW:0]   CAP_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d, err_q, err_d, cap, lvl;
  logic          ovr_q, ovr_d, fen_q;
  logic          flush, push_ok, pop_ok, in_err, head_err;
  rx_entry_t     wentry, rentry, head;

  // Toggling the FIFO mode discards whatever was queued, same as FCR[1].
  assign flush    = clr | (fifo_en != fen_q);
  assign empty    = (count_q == '0);
  assign cap      = fifo_en ? CAP_MAX : CNT_ONE;
  assign full     = (count_q == cap);
  assign pop_ok   = pop & ~empty & ~flush;
  assign push_ok  = push & ~flush & ((count_q < cap) | pop_ok);
  assign ovr_d    = push & ~flush & ~push_ok;
  assign in_err   = pe_in | fe_in | bi_in;
  assign head_err = rentry.pe | rentry.fe | rentry.bi;
  assign wentry   = '{bi: bi_in, fe: fe_in, pe: pe_in, data: din};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      err_d   = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_ONE;
      if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      case ({push_ok & in_err, pop_ok & head_err})
        2'b10:   err_d = err_q + CNT_ONE;
        2'b01:   err_d = err_q - CNT_ONE;
        default: err_d = err_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= '0;
      ovr_q   <= 1'b0;
      fen_q   <= fifo_en;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      fen_q   <= fifo_en;
    end
  end

  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wptr_q),
    .wdata (wentry),
    .raddr (rptr_q),
    .rdata (rentry)
  );

  assign head        = empty ? '0 : rentry;
  assign dout        = head.data;
  assign pe_out      = head.pe;
  assign fe_out      = head.fe;
  assign bi_out      = head.bi;
  assign count       = count_q;
  assign overrun     = ovr_q;
  assign err_in_fifo = (err_q != '0);
  assign lvl         = (AW+1)'(trig_level(trig_lvl));
  assign trig_hit    = fifo_en ? (count_q >= lvl) : ~empty;

`ifdef UART_RX_TIMEOUT_EN
  logic [2:0] idle_q, idle_d;
  logic       to_q, to_d;

  // Counter saturates at the threshold; any FIFO access restarts the idle window.
  always_comb begin
    idle_d = idle_q;
    if (flush | push | pop)
      idle_d = '0;
    else if (char_tick && !empty && idle_q != CHAR_TO_THR)
      idle_d = idle_q + 3'd1;
    to_d = (idle_d == CHAR_TO_THR) && (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end

  assign timeout = to_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic vs. a queue model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst, push, pop, fifo_en, clr, pe_in, fe_in, bi_in;
  logic [7:0] din;
  logic [1:0] trig_lvl;
  logic [7:0] dout;
  logic       pe_out, fe_out, bi_out, empty, full, overrun, trig_hit, err_in_fifo;
  logic [4:0] count;
`ifdef UART_RX_TIMEOUT_EN
  logic       char_tick, timeout;
`endif

  int vecs = 0;
  int errs = 0;

  // Reference model: queue of {bi,fe,pe,data}, mode seen last cycle, expected overrun.
  logic [10:0] mq[$];
  bit          m_fen;
  bit          m_ovr;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in),
    .pop(pop), .fifo_en(fifo_en), .clr(clr), .trig_lvl(trig_lvl),
`ifdef UART_RX_TIMEOUT_EN
    .char_tick(char_tick), .timeout(timeout),
`endif
    .dout(dout), .pe_out(pe_out), .fe_out(fe_out), .bi_out(bi_out), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .trig_hit(trig_hit), .err_in_fifo(err_in_fifo)
  );

  task automatic model_step(input bit ps, input logic [10:0] e, input bit pp, input bit cl);
    int  cap  = fifo_en ? 16 : 1;
    bit  fl   = cl || (fifo_en != m_fen);
    bit  room;
    bit  dpop;
    m_fen = fifo_en;
    m_ovr = 0;
    if (fl) mq.delete();
    else begin
      dpop = pp && mq.size() > 0;
      room = mq.size() < cap || dpop;
      if (dpop) void'(mq.pop_front());
      if (ps) begin
        if (room) mq.push_back(e);
        else m_ovr = 1;
      end
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
  task automatic drive(input bit ps, input logic [7:0] d, input logic [2:0] flg, input bit pp, input bit cl);
    push = ps; din = d; {bi_in, fe_in, pe_in} = flg; pop = pp; clr = cl;
    model_step(ps, {flg, d}, pp, cl);
    @(posedge clk); #1;
    push = 0; pop = 0; clr = 0; din = 0; {bi_in, fe_in, pe_in} = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    mq.delete();
    m_fen = fifo_en;
    m_ovr = 0;
  endtask

  task automatic test_reset();
    fifo_en = 1; trig_lvl = 2'b00;
    do_reset();
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b want 1", empty); end
    vecs++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", full); end
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
    vecs++; if ({overrun, trig_hit, err_in_fifo} !== 3'b000)
      begin errs++; $display("FAIL reset_flags got %b want 000", {overrun, trig_hit, err_in_fifo}); end
    vecs++; if ({dout, pe_out, fe_out, bi_out} !== 11'd0)
      begin errs++; $display("FAIL reset_head got %h want 0", {dout, pe_out, fe_out, bi_out}); end
  endtask

  task automatic test_basic();
    logic [7:0] expd [3] = '{8'h42, 8'h43, 8'h00};
    do_reset();
    drive(1, 8'h41, 0, 0, 0); drive(1, 8'h42, 0, 0, 0); drive(1, 8'h43, 0, 0, 0);
    vecs++; if (count !== 5'd3) begin errs++; $display("FAIL basic_count got %0d want 3", count); end
    vecs++; if (dout !== 8'h41) begin errs++; $display("FAIL basic_head got %h want 41", dout); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      vecs++; if (dout !== expd[i]) begin errs++; $display("FAIL basic_pop%0d got %h want %h", i, dout, expd[i]); end
    end
    vecs++; if (empty !== 1'b1 || count !== 5'd0)
      begin errs++; $display("FAIL basic_drain got empty=%b count=%0d want 1/0", empty, count); end
  endtask

  task automatic test_full_overrun();
    do_reset();
    for (int i = 0; i < 16; i++) drive(1, 8'(i), 0, 0, 0);
    vecs++; if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0)
      begin errs++; $display("FAIL full_after16 got full=%b count=%0d ovr=%b want 1/16/0", full, count, overrun); end
    drive(1, 8'h10, 0, 0, 0);
    vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL full_overrun got %b want 1", overrun); end
    vecs++; if (dout !== 8'h00 || count !== 5'd16)
      begin errs++; $display("FAIL full_keep got head=%h count=%0d want 00/16", dout, count); end
    drive(0, 0, 0, 0, 0);
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL overrun_pulse got %b want 0", overrun); end
    drive(1, 8'hAA, 0, 1, 0);
    vecs++; if (count !== 5'd16 || overrun !== 1'b0 || dout !== 8'h01)
      begin errs++; $display("FAIL full_pushpop got count=%0d ovr=%b head=%h want 16/0/01", count, overrun, dout); end
    for (int i = 0; i < 14; i++) drive(0, 0, 0, 1, 0);
    vecs++; if (dout !== 8'h0F) begin errs++; $display("FAIL full_tail got %h want 0f", dout); end
    drive(0, 0, 0, 1, 0);
    vecs++; if (dout !== 8'hAA) begin errs++; $display("FAIL full_last got %h want aa", dout); end
  endtask

  task automatic test_trigger();
    do_reset();
    trig_lvl = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 8'(i), 0, 0, 0);
      vecs++; if (trig_hit !== (i >= 8)) begin errs++; $display("FAIL trig_push%0d got %b want %b", i, trig_hit, i >= 8); end
    end
    drive(0, 0, 0, 1, 0);
    vecs++; if (trig_hit !== 1'b0) begin errs++; $display("FAIL trig_fall got %b want 0", trig_hit); end
    trig_lvl = 2'b00;
  endtask

  task automatic test_err_flag();
    do_reset();
    drive(1, 8'h10, 3'b000, 0, 0); drive(1, 8'h55, 3'b010, 0, 0); drive(1, 8'h20, 3'b000, 0, 0);
    vecs++; if (err_in_fifo !== 1'b1 || fe_out !== 1'b0)
      begin errs++; $display("FAIL err_set got err=%b fe=%b want 1/0", err_in_fifo, fe_out); end
    drive(0, 0, 0, 1, 0);
    vecs++; if (err_in_fifo !== 1'b1 || dout !== 8'h55 || fe_out !== 1'b1)
      begin errs++; $display("FAIL err_head got err=%b head=%h fe=%b want 1/55/1", err_in_fifo, dout, fe_out); end
    drive(0, 0, 0, 1, 0);
    vecs++; if (err_in_fifo !== 1'b0 || dout !== 8'h20)
      begin errs++; $display("FAIL err_clear got err=%b head=%h want 0/20", err_in_fifo, dout); end
  endtask

  task automatic test_16450();
    do_reset();
    drive(1, 8'h77, 0, 0, 0);
    fifo_en = 0;
    drive(0, 0, 0, 0, 0);
    vecs++; if (empty !== 1'b1 || trig_hit !== 1'b0)
      begin errs++; $display("FAIL mode_flush got empty=%b trig=%b want 1/0", empty, trig_hit); end
    drive(1, 8'h11, 0, 0, 0);
    vecs++; if (full !== 1'b1 || trig_hit !== 1'b1 || count !== 5'd1)
      begin errs++; $display("FAIL hold_one got full=%b trig=%b count=%0d want 1/1/1", full, trig_hit, count); end
    drive(1, 8'h22, 0, 0, 0);
    vecs++; if (overrun !== 1'b1 || dout !== 8'h11)
      begin errs++; $display("FAIL hold_overrun got ovr=%b head=%h want 1/11", overrun, dout); end
    drive(1, 8'h33, 0, 0, 1);
    vecs++; if (empty !== 1'b1 || overrun !== 1'b0)
      begin errs++; $display("FAIL hold_clr got empty=%b ovr=%b want 1/0", empty, overrun); end
    fifo_en = 1;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int lvl_tab [4] = '{1, 4, 8, 14};
    int ecnt;
    logic [10:0] eh;
    bit etrig;
    fifo_en = 1; trig_lvl = 2'b00;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 49) == 0) fifo_en = ~fifo_en;
      if ($urandom_range(0, 19) == 0) trig_lvl = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 99) < 60, 8'($urandom),
            {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0},
            $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 3);
      ecnt = 0;
      foreach (mq[i]) if (mq[i][10:8] != 3'b000) ecnt++;
      eh    = (mq.size() > 0) ? mq[0] : 11'd0;
      etrig = m_fen ? (mq.size() >= lvl_tab[trig_lvl]) : (mq.size() != 0);
      vecs++; if (count !== 5'(mq.size())) begin errs++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, count, mq.size()); end
      vecs++; if (empty !== (mq.size() == 0) || full !== (mq.size() == (m_fen ? 16 : 1)))
        begin errs++; $display("FAIL rnd_status n=%0d got empty=%b full=%b qsize=%0d", n, empty, full, mq.size()); end
      vecs++; if ({bi_out, fe_out, pe_out, dout} !== eh)
        begin errs++; $display("FAIL rnd_head n=%0d got %h want %h", n, {bi_out, fe_out, pe_out, dout}, eh); end
      vecs++; if (overrun !== m_ovr) begin errs++; $display("FAIL rnd_overrun n=%0d got %b want %b", n, overrun, m_ovr); end
      vecs++; if (trig_hit !== etrig) begin errs++; $display("FAIL rnd_trig n=%0d got %b want %b", n, trig_hit, etrig); end
      vecs++; if (err_in_fifo !== (ecnt != 0)) begin errs++; $display("FAIL rnd_err n=%0d got %b want %b", n, err_in_fifo, ecnt != 0); end
    end
  endtask

`ifdef UART_RX_TIMEOUT_EN
  task automatic tick();
    char_tick = 1; @(posedge clk); #1; char_tick = 0;
  endtask

  task automatic test_timeout();
    fifo_en = 1;
    do_reset();
    drive(1, 8'h5A, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      vecs++; if (timeout !== (i == 4)) begin errs++; $display("FAIL to_tick%0d got %b want %b", i, timeout, i == 4); end
    end
    drive(0, 0, 0, 1, 0);
    vecs++; if (timeout !== 1'b0) begin errs++; $display("FAIL to_pop got %b want 0", timeout); end
    for (int i = 0; i < 10; i++) tick();
    vecs++; if (timeout !== 1'b0) begin errs++; $display("FAIL to_empty got %b want 0", timeout); end
  endtask
`endif

  initial begin
    rst = 1; push = 0; pop = 0; clr = 0; din = 0; pe_in = 0; fe_in = 0; bi_in = 0;
    fifo_en = 1; trig_lvl = 0;
`ifdef UART_RX_TIMEOUT_EN
    char_tick = 0;
`endif
    test_reset();
    test_basic();
    test_full_overrun();
    test_trigger();
    test_err_flag();
    test_16450();
    test_random();
`ifdef UART_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
